seven_seg_scan_ctrl: RTL
========================

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 4: clock cycles each digit is lit; legal range 1..255.
REQ-002 SHALL have parameter BLANK, default 1: all-dark cycles after each digit; legal range 0..255.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port upd_val  input  1  requester offers a new 4-digit value.
REQ-006 SHALL have port upd_data  input  16  new value; nibble i (bits 4i+3:4i) is digit i, digit 0 rightmost.
REQ-007 SHALL have port upd_rdy  output  1  block can accept an update this cycle.
REQ-008 SHALL have port dec_in  output  4  binary nibble driven to the shared binary-to-seven-seg decoder.
REQ-009 SHALL have port an  output  4  digit enables, active-low, at most one bit low.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse at end of each full scan.

Function
REQ-011 SHALL hold a 16-bit display register disp, a 16-bit pending buffer pbuf with flag pend, a 2-bit digit index dig, an 8-bit phase counter cnt, and a 2-state FSM {SHOW, BLANK}.
REQ-012 SHALL drive upd_rdy = !pend; an update is accepted on a rising edge where upd_val && upd_rdy, loading pbuf and setting pend.
REQ-013 SHALL ignore upd_data whenever upd_val is 0 or upd_rdy is 0.
REQ-014 SHALL drive dec_in = disp nibble selected by dig, decoded from registered state only.
REQ-015 SHALL drive an with bit dig low and others high in SHOW, and an = 4'b1111 in BLANK.
REQ-016 In SHOW, cnt SHALL count 0..DIV-1; at cnt == DIV-1, cnt clears and the FSM moves to BLANK if BLANK > 0, else dig advances and the FSM stays in SHOW.
REQ-017 In BLANK, cnt SHALL count 0..BLANK-1; at cnt == BLANK-1, cnt clears, dig advances, and the FSM returns to SHOW.
REQ-018 dig SHALL advance 0->1->2->3->0; the 3->0 advance is the frame boundary.
REQ-019 Frame period SHALL be exactly 4*(DIV+BLANK) cycles.
REQ-020 At the frame-boundary edge, if pend = 1, disp SHALL load pbuf and pend SHALL clear; upd_rdy rises the following cycle.
REQ-021 An update SHALL never reach disp mid-frame; disp changes only at a frame boundary.
REQ-022 frame_done SHALL be registered and high for exactly the one cycle following each frame-boundary edge.

Reset
REQ-023 While rst = 0, SHALL immediately force disp = 0, pbuf = 0, pend = 0, dig = 0, cnt = 0, FSM = SHOW, frame_done = 0.
REQ-024 During and after reset, outputs SHALL be an = 4'b1110, dec_in = 4'h0, upd_rdy = 1, frame_done = 0.
REQ-025 Reset asserted mid-frame SHALL discard any pending update; scanning restarts at digit 0, cnt 0, on the first edge after release.

Configuration
REQ-026 Macro SEVEN_SEG_LEADING_ZERO_BLANK_EN defined: during SHOW of digit i (i = 3..1), an SHALL be 4'b1111 if nibble i and all higher nibbles of disp are 0; digit 0 is always lit; slot timing and dig sequencing are unchanged.
REQ-027 Macro not defined: all four digits SHALL be lit in their SHOW slots regardless of value.

Verification (DIV = 4, BLANK = 1 unless stated)
REQ-028 Reset asserted then released -> an = 1110, dec_in = 0, upd_rdy = 1, frame_done = 0; after 20 cycles frame_done pulses once.
REQ-029 Accept 16'h1234 in frame 0 -> from frame 1: an=1110 with dec_in=4 for 4 cycles, an=1111 for 1 cycle, an=1101 with dec_in=3, an=1011 with dec_in=2, an=0111 with dec_in=1; frame_done every 20 cycles.
REQ-030 Offer 16'hAAAA, then hold upd_val with 16'h5555 -> upd_rdy = 0 until the cycle after the next frame boundary; 5555 is accepted then and is displayed one frame after AAAA.
REQ-031 Pulse rst low for one cycle while dig = 2 with pend = 1 -> an = 1110 immediately, disp = 0, pend = 0, upd_rdy = 1; the pending value never appears.
REQ-032 disp = 16'h0050: with the macro, digits 3 and 2 show an = 1111, digit 1 shows an = 1101 with dec_in = 5, digit 0 shows an = 1110 with dec_in = 0; without the macro, all four digits are lit.
REQ-033 BLANK = 0, DIV = 1 -> an cycles 1110, 1101, 1011, 0111 on consecutive cycles with no 1111 cycles; frame_done every 4 cycles.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_ctrl
//
// Time-multiplexed driver for a 4-digit common-anode seven-segment display
// that shares a single binary-to-seven-segment decoder. Each digit is lit
// for DIV cycles, followed by BLANK all-dark cycles so that the previous
// digit's segments do not ghost onto the next one. One full scan of the
// four digits is a "frame" of 4*(DIV+BLANK) cycles.
//
// New values are taken through a valid/ready handshake into a pending
// buffer and are copied into the display register only at a frame
// boundary, so a frame never shows a mix of old and new digits.
//
// Parameters
//   DIV    : cycles each digit is lit (1..255)
//   BLANK  : all-dark cycles after each digit (0..255)
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous reset, active low
//   upd_val    in   1   requester offers a new 4-digit value
//   upd_data   in  16   new value, nibble i is digit i (digit 0 rightmost)
//   upd_rdy    out  1   an update can be accepted this cycle
//   dec_in     out  4   nibble for the shared seven-segment decoder
//   an         out  4   digit enables, active low, at most one low
//   frame_done out  1   one-cycle pulse after each frame boundary
//
// Build option
//   SEVEN_SEG_LEADING_ZERO_BLANK_EN : when defined, leading zero digits
//   (digit 3 down to digit 1) stay dark during their slot. Digit 0 is
//   always lit. Slot timing is unaffected.
// -----------------------------------------------------------------------------
module seven_seg_scan_ctrl #(
  parameter int unsigned DIV   = 4,
  parameter int unsigned BLANK = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upd_val,
  input  logic [15:0] upd_data,
  output logic        upd_rdy,
  output logic [3:0]  dec_in,
  output logic [3:0]  an,
  output logic        frame_done
);

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  // Terminal counts of the two phases. With BLANK == 0 the blank phase is
  // never entered, so its terminal count is a don't-care.
  localparam logic [7:0] DIV_LAST   = 8'(DIV - 1);
  localparam logic [7:0] BLANK_LAST = (BLANK > 0) ? 8'(BLANK - 1) : 8'd0;
  localparam bit         HAS_BLANK  = (BLANK > 0);

  // Registered state
  state_t      state_q,      state_d;
  logic [1:0]  dig_q,        dig_d;
  logic [7:0]  cnt_q,        cnt_d;
  logic [15:0] disp_q,       disp_d;
  logic [15:0] pbuf_q,       pbuf_d;
  logic        pend_q,       pend_d;
  logic        frame_done_q, frame_done_d;
  logic [3:0]  an_q,         an_d;
  logic [3:0]  dec_in_q,     dec_in_d;

  // Scan bookkeeping
  logic        dig_adv;     // digit index advances on this edge
  logic        frame_end;   // the 3 -> 0 advance: frame boundary

  // Output decode helpers, all computed from next-state values so the
  // outputs can be registered alongside the state they describe.
  logic [3:0]  dig_sel;     // one-hot of dig_d
  logic [3:0]  upper_zero;  // upper_zero[i]: nibbles i..3 of disp_d all zero
  logic        suppress;    // current digit is a leading zero to be hidden

  // ---------------------------------------------------------------------------
  // Next-state logic: phase counter, FSM, digit index, update buffering
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    dig_d        = dig_q;
    cnt_d        = cnt_q;
    disp_d       = disp_q;
    pbuf_d       = pbuf_q;
    pend_d       = pend_q;
    dig_adv      = 1'b0;
    frame_end    = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      ST_SHOW: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = 8'd0;
          if (HAS_BLANK) begin
            state_d = ST_BLANK;
          end else begin
            dig_adv = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = 8'd0;
          state_d = ST_SHOW;
          dig_adv = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_SHOW;
        cnt_d   = 8'd0;
      end
    endcase

    if (dig_adv) begin
      dig_d = dig_q + 2'd1;
    end
    frame_end    = dig_adv && (dig_q == 2'd3);
    frame_done_d = frame_end;

    // The pending value is promoted only between frames. Acceptance needs
    // pend_q == 0 and promotion needs pend_q == 1, so the two never collide
    // on the same edge.
    if (frame_end && pend_q) begin
      disp_d = pbuf_q;
      pend_d = 1'b0;
    end
    if (upd_val && !pend_q) begin
      pbuf_d = upd_data;
      pend_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-digit decode of the next state
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    assign dig_sel[gi]    = (dig_d == 2'(gi));
    assign upper_zero[gi] = ~|disp_d[15:4*gi];
  end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  // Digit 0 is always shown so that a value of zero still displays "0".
  assign suppress = (dig_d != 2'd0) && upper_zero[dig_d];
`else
  assign suppress = 1'b0;
`endif

  always_comb begin
    dec_in_d = disp_d[{dig_d, 2'b00} +: 4];
    an_d     = 4'b1111;
    if ((state_d == ST_SHOW) && !suppress) begin
      an_d = ~dig_sel;
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_SHOW;
      dig_q        <= 2'd0;
      cnt_q        <= 8'd0;
      disp_q       <= 16'h0000;
      pbuf_q       <= 16'h0000;
      pend_q       <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= 4'b1110;
      dec_in_q     <= 4'h0;
    end else begin
      state_q      <= state_d;
      dig_q        <= dig_d;
      cnt_q        <= cnt_d;
      disp_q       <= disp_d;
      pbuf_q       <= pbuf_d;
      pend_q       <= pend_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      dec_in_q     <= dec_in_d;
    end
  end

  assign upd_rdy    = !pend_q;
  assign dec_in     = dec_in_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
